// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer that fetches one instruction at a
// time, holds it while it executes, then moves to the next sequential or
// branch target address.
// Optional feature macro: BRANCH_LINK_EN. When it is defined, a taken link
// branch (kind 10) writes the return address (old pc + 4) to the link register
// through a one-cycle link_we pulse. When it is undefined, link_we and
// link_data are tied to zero.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        do_branch,
  input  logic [1:0]  branch_kind,
  input  logic [31:0] br_offset,
  input  logic [31:0] rs_value,
  input  logic        instr_done,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    EXEC   = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] seq_target;
  logic [31:0] branch_target;
  logic [31:0] next_target;
  logic        branch_taken;

  // Candidate next addresses. Kind 11 is reserved and falls back to sequential.
  always_comb begin
    seq_target    = pc_q + 32'd4;
    branch_target = (branch_kind == 2'b01) ? rs_value : (pc_q + br_offset);
    branch_taken  = do_branch && (branch_kind != 2'b11);
    next_target   = branch_taken ? branch_target : seq_target;
  end

  // Next-state logic; every output is produced from a register loaded with these values.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      FETCH: begin
        // An ack only counts once the request is actually on the bus; this
        // discards a stale ack in the first cycle after reset.
        if (req_q && imem_ack) begin
          state_d = EXEC;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      EXEC: begin
        if (instr_done) begin
          valid_d = 1'b0;
          if (halt) begin
            state_d  = HALTED;
            req_d    = 1'b0;
            halted_d = 1'b1;
          end else begin
            state_d = FETCH;
            req_d   = 1'b1;
            pc_d    = next_target & 32'hFFFF_FFFC;
          end
        end
      end
      HALTED: begin
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d  = FETCH;
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= 32'd0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

`ifdef BRANCH_LINK_EN
  logic        link_we_q;
  logic [31:0] link_data_q;
  logic        link_fire;

  // A link write fires only when a taken kind-10 branch retires without halt.
  always_comb begin
    link_fire = (state_q == EXEC) && instr_done && !halt && do_branch &&
                (branch_kind == 2'b10);
  end

  // Link register write port: one-cycle pulse, return address is held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_we_q   <= 1'b0;
      link_data_q <= 32'd0;
    end else begin
      link_we_q <= link_fire;
      if (link_fire) begin
        link_data_q <= pc_q + 32'd4;
      end
    end
  end

  assign link_we   = link_we_q;
  assign link_data = link_data_q;
`else
  assign link_we   = 1'b0;
  assign link_data = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a fixed vector table, hand-written
// corner sequences, then randomized stimulus against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_branch;
  logic [1:0]  branch_kind;
  logic [31:0] br_offset;
  logic [31:0] rs_value;
  logic        instr_done;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] pc;
  logic        instr_valid;
  logic        link_we;
  logic [31:0] link_data;
  logic        halted;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: tracks what the outside world should observe.
  logic [31:0] m_pc;
  logic        m_req, m_valid, m_halted, m_lwe;
  logic [31:0] m_ldata;

`ifdef BRANCH_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .do_branch  (do_branch),
    .branch_kind(branch_kind),
    .br_offset  (br_offset),
    .rs_value   (rs_value),
    .instr_done (instr_done),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .pc         (pc),
    .instr_valid(instr_valid),
    .link_we    (link_we),
    .link_data  (link_data),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ack, done, halt, br;
    logic [1:0]  kind;
    logic [31:0] off, rs;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid, exp_halted;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic r, input logic a, input logic d, input logic h,
                              input logic b, input logic [1:0] k, input logic [31:0] o,
                              input logic [31:0] s, input logic er, input logic [31:0] ea,
                              input logic ev, input logic eh);
    vec_t v;
    v.rst = r; v.ack = a; v.done = d; v.halt = h; v.br = b; v.kind = k;
    v.off = o; v.rs = s; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
    v.exp_halted = eh;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic modelStep();
    logic [31:0] old_pc;
    old_pc = m_pc;
    m_lwe  = 1'b0;
    if (rst) begin
      m_pc = 0; m_req = 0; m_valid = 0; m_halted = 0; m_ldata = 0;
    end else if (m_halted) begin
      m_req = 0;
    end else if (m_valid) begin
      if (instr_done) begin
        m_valid = 0;
        if (halt) begin
          m_halted = 1;
        end else begin
          m_req = 1;
          if (do_branch && branch_kind == 2'd1) begin
            m_pc = rs_value & 32'hFFFF_FFFC;
          end else if (do_branch && branch_kind != 2'd3) begin
            m_pc = (old_pc + br_offset) & 32'hFFFF_FFFC;
            if (LINK_EN && branch_kind == 2'd2) begin
              m_lwe   = 1;
              m_ldata = old_pc + 32'd4;
            end
          end else begin
            m_pc = old_pc + 32'd4;
          end
        end
      end
    end else begin
      if (m_req && imem_ack) begin
        m_req = 0; m_valid = 1;
      end else begin
        m_req = 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a, input logic d, input logic h,
                               input logic b, input logic [1:0] k, input logic [31:0] o,
                               input logic [31:0] s);
    rst = r; imem_ack = a; instr_done = d; halt = h; do_branch = b;
    branch_kind = k; br_offset = o; rs_value = s;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " imem_req"},    32'(imem_req),    32'(m_req));
    checkOutput({tag, " imem_addr"},   imem_addr,        m_pc);
    checkOutput({tag, " pc"},          pc,               m_pc);
    checkOutput({tag, " instr_valid"}, 32'(instr_valid), 32'(m_valid));
    checkOutput({tag, " halted"},      32'(halted),      32'(m_halted));
    checkOutput({tag, " link_we"},     32'(link_we),     32'(m_lwe));
    checkOutput({tag, " link_data"},   link_data,        m_ldata);
  endtask

  initial begin
    // Vector table: rst ack done halt br kind off rs | req addr valid halted
    vecs[0]  = mk(1,0,0,0,0,2'd0,32'h0,32'h0,         0,32'h0,0,0);
    vecs[1]  = mk(0,0,0,0,0,2'd0,32'h0,32'h0,         1,32'h0,0,0);
    vecs[2]  = mk(0,0,0,0,0,2'd0,32'h0,32'h0,         1,32'h0,0,0);
    vecs[3]  = mk(0,0,0,0,0,2'd0,32'h0,32'h0,         1,32'h0,0,0);
    vecs[4]  = mk(0,1,0,0,0,2'd0,32'h0,32'h0,         0,32'h0,1,0);
    vecs[5]  = mk(0,0,1,0,1,2'd1,32'h0,32'h103,       1,32'h100,0,0);
    vecs[6]  = mk(0,1,0,0,0,2'd0,32'h0,32'h0,         0,32'h100,1,0);
    vecs[7]  = mk(0,0,1,0,0,2'd0,32'h0,32'h0,         1,32'h104,0,0);
    vecs[8]  = mk(0,1,0,0,0,2'd0,32'h0,32'h0,         0,32'h104,1,0);
    vecs[9]  = mk(0,0,1,0,1,2'd0,32'hFFFF_FFF4,32'h0, 1,32'hF8,0,0);
    vecs[10] = mk(0,1,0,0,0,2'd0,32'h0,32'h0,         0,32'hF8,1,0);
    vecs[11] = mk(0,0,1,0,1,2'd1,32'h0,32'h203,       1,32'h200,0,0);
    vecs[12] = mk(0,1,0,0,0,2'd0,32'h0,32'h0,         0,32'h200,1,0);
    vecs[13] = mk(0,0,1,0,1,2'd3,32'h40,32'h800,      1,32'h204,0,0);
    vecs[14] = mk(0,1,1,0,0,2'd0,32'h0,32'h0,         0,32'h204,1,0);
    vecs[15] = mk(0,0,1,0,1,2'd1,32'h0,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,0,0);
    vecs[16] = mk(0,1,0,0,0,2'd0,32'h0,32'h0,         0,32'hFFFF_FFFC,1,0);
    vecs[17] = mk(0,0,1,0,0,2'd0,32'h0,32'h0,         1,32'h0,0,0);
    vecs[18] = mk(0,0,1,0,1,2'd1,32'h0,32'h300,       1,32'h0,0,0);
    vecs[19] = mk(0,1,0,0,0,2'd0,32'h0,32'h0,         0,32'h0,1,0);
    vecs[20] = mk(0,0,1,1,1,2'd1,32'h0,32'h500,       0,32'h0,0,1);
    vecs[21] = mk(0,1,0,0,0,2'd0,32'h0,32'h0,         0,32'h0,0,1);
    vecs[22] = mk(0,1,1,0,1,2'd0,32'h10,32'h0,        0,32'h0,0,1);
    vecs[23] = mk(1,0,0,0,0,2'd0,32'h0,32'h0,         0,32'h0,0,0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ack, vecs[i].done, vecs[i].halt, vecs[i].br,
                    vecs[i].kind, vecs[i].off, vecs[i].rs);
      checkOutput($sformatf("vec%0d imem_req", i),    32'(imem_req),    32'(vecs[i].exp_req));
      checkOutput($sformatf("vec%0d imem_addr", i),   imem_addr,        vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d pc", i),          pc,               vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d halted", i),      32'(halted),      32'(vecs[i].exp_halted));
      checkOutput($sformatf("vec%0d link_we", i),     32'(link_we),     32'd0);
    end

    // Link branch: pc 0x40, kind 10, offset 0x20 taken.
    applyStimulus(1,0,0,0,0,2'd0,32'h0,32'h0);
    applyStimulus(0,0,0,0,0,2'd0,32'h0,32'h0);
    applyStimulus(0,1,0,0,0,2'd0,32'h0,32'h0);
    applyStimulus(0,0,1,0,1,2'd1,32'h0,32'h40);
    applyStimulus(0,1,0,0,0,2'd0,32'h0,32'h0);
    checkOutput("link pre pc", pc, 32'h40);
    applyStimulus(0,0,1,0,1,2'd2,32'h20,32'h0);
    checkOutput("link pc", pc, 32'h60);
    checkOutput("link imem_req", 32'(imem_req), 32'd1);
    checkOutput("link we pulse", 32'(link_we), LINK_EN ? 32'd1 : 32'd0);
    checkOutput("link data", link_data, LINK_EN ? 32'h44 : 32'h0);
    applyStimulus(0,0,0,0,0,2'd0,32'h0,32'h0);
    checkOutput("link we drop", 32'(link_we), 32'd0);
    checkOutput("link data hold", link_data, LINK_EN ? 32'h44 : 32'h0);

    // Reset arriving together with an ack mid-handshake.
    applyStimulus(0,1,0,0,0,2'd0,32'h0,32'h0);
    applyStimulus(0,0,1,0,0,2'd0,32'h0,32'h0);
    checkOutput("rstack pre req", 32'(imem_req), 32'd1);
    checkOutput("rstack pre addr", imem_addr, 32'h64);
    applyStimulus(1,1,0,0,0,2'd0,32'h0,32'h0);
    checkOutput("rstack pc", pc, 32'h0);
    checkOutput("rstack valid", 32'(instr_valid), 32'd0);
    checkOutput("rstack req", 32'(imem_req), 32'd0);
    checkOutput("rstack link_data", link_data, 32'h0);
    applyStimulus(0,0,0,0,0,2'd0,32'h0,32'h0);
    checkOutput("rstack refetch req", 32'(imem_req), 32'd1);
    checkOutput("rstack refetch addr", imem_addr, 32'h0);
    applyStimulus(0,1,0,0,0,2'd0,32'h0,32'h0);
    checkOutput("rstack refetch valid", 32'(instr_valid), 32'd1);

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] off;
      off = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 512)) - 256)
                                        : $urandom;
      applyStimulus($urandom_range(0, 59) == 0, 1'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 39) == 0, 1'($urandom), 2'($urandom), off, $urandom);
      checkModel($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: do_branch  in  1  branch decision from branch-condition unit, sampled only on instr_done.
REQ-004 SHALL have ports: branch_kind  in  2  00 PC-relative (b/bcy/bz...), 01 register (br rs), 10 link (bl L), 11 reserved.
REQ-005 SHALL have ports: br_offset  in  32  sign-extended byte offset, relative to current pc.
REQ-006 SHALL have ports: rs_value  in  32  register target for kind 01.
REQ-007 SHALL have ports: instr_done  in  1  control signals current instruction complete.
REQ-008 SHALL have ports: halt  in  1  stop sequencing, sampled with instr_done.
REQ-009 SHALL have ports: imem_req  out  1, imem_addr  out  32, imem_ack  in  1  instruction-memory fetch handshake.
REQ-010 SHALL have ports: pc  out  32  address of instruction in execution; instr_valid  out  1  fetched instruction present.
REQ-011 SHALL have ports: link_we  out  1, link_data  out  32  return-address write to link register.
REQ-012 SHALL have ports: halted  out  1  sequencer in HALTED state.

Function
REQ-013 SHALL implement states FETCH, EXEC, HALTED; all outputs registered.
REQ-014 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack -> EXEC next cycle.
REQ-015 EXEC: instr_valid=1, imem_req=0; wait for instr_done; imem_ack in EXEC/HALTED ignored.
REQ-016 On instr_done with halt=1 -> HALTED, pc unchanged; halt wins over do_branch.
REQ-017 On instr_done, halt=0, do_branch=0 or branch_kind=11: pc <= pc+4 -> FETCH.
REQ-018 On instr_done, halt=0, do_branch=1: kind 00/10 pc <= pc+br_offset; kind 01 pc <= rs_value -> FETCH.
REQ-019 Target bits [1:0] SHALL be forced to 00; all address arithmetic modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-020 Latency: instr_done cycle -> imem_req=1 with new address in the very next cycle.
REQ-021 HALTED: imem_req=0, instr_valid=0, halted=1; left only by rst.
REQ-022 instr_done outside EXEC SHALL be ignored.

Reset
REQ-023 rst=1 at any edge (including mid-handshake) SHALL force pc=0, state FETCH, imem_req=0 for that cycle, instr_valid=0, link_we=0, link_data=0, halted=0; pending ack discarded.
REQ-024 First cycle after rst deasserts SHALL drive imem_req=1, imem_addr=0.

Configuration
REQ-025 Macro BRANCH_LINK_EN defined: kind 10 taken SHALL pulse link_we=1 for exactly one cycle (the cycle after instr_done) with link_data=old pc+4.
REQ-026 BRANCH_LINK_EN undefined: link_we and link_data tied 0; kind 10 behaves as kind 00.

Verification
REQ-027 Reset then ack after 3 cycles -> imem_addr=0 held 3 cycles, instr_valid=1 one cycle after ack, pc=0.
REQ-028 pc=0x100, instr_done, do_branch=0 -> next cycle imem_req=1, imem_addr=0x104.
REQ-029 pc=0x100, kind 00, br_offset=-8, taken -> pc=0x0F8; kind 01 rs_value=0x203 -> pc=0x200.
REQ-030 BRANCH_LINK_EN, pc=0x40, kind 10, offset 0x20, taken -> pc=0x60, link_we one-cycle pulse, link_data=0x44; without macro link_we stays 0.
REQ-031 pc=0xFFFFFFFC sequential -> pc=0x00000000; halt+do_branch together -> halted=1, pc unchanged, later acks ignored.
REQ-032 rst asserted while imem_req=1 awaiting ack, ack arrives same cycle -> pc=0, instr_valid=0, fetch restarts at 0.
